// File: rtl/bc_io_unit.sv
// Basic-computer I/O unit: INPR/OUTR with FGI/FGO flags, IEN and registered irq,
// bridging controller I/O strobes to a valid/ready byte stream toward the device.
//
// state   | meaning
// TX_IDLE | OUTR empty, fgo = 1, tx_valid = 0
// TX_BUSY | OUTR holds an unsent byte, fgo = 0, tx_valid = 1
module bc_io_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_inp,
    input  logic              cpu_out,
    input  logic              cpu_ion,
    input  logic              cpu_iof,
    input  logic              irq_ack,
    input  logic [DATA_W-1:0] ac_lo,
    output logic [DATA_W-1:0] inpr_q,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              irq,
    output logic              err_ovr,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    tx_state_t         r_tx_state;
    logic [DATA_W-1:0] r_inpr;
    logic [DATA_W-1:0] r_outr;
    logic              r_fgi;
    logic              r_ien;
    logic              r_irq;
    logic              r_err_ovr;
    logic              w_rx_take;
    logic              w_fgo;

    assign w_rx_take = rx_valid & ~r_fgi;
    assign w_fgo     = (r_tx_state == TX_IDLE);

    // A capture wins over a same-cycle INP so a byte offered while fgi = 0 is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inpr <= '0;
            r_fgi  <= 1'b0;
        end else if (w_rx_take) begin
            r_inpr <= rx_data;
            r_fgi  <= 1'b1;
        end else if (cpu_inp) begin
            r_fgi  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_outr     <= '0;
            r_err_ovr  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (cpu_out) begin
                        r_outr     <= ac_lo;
                        r_tx_state <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    // OUT while busy (including the completing cycle) is dropped and flagged.
                    if (cpu_out)
                        r_err_ovr <= 1'b1;
                    if (tx_ready)
                        r_tx_state <= TX_IDLE;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ien <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (irq_ack || cpu_iof)
                r_ien <= 1'b0;
            else if (cpu_ion)
                r_ien <= 1'b1;
            r_irq <= r_ien & (r_fgi | w_fgo);
        end
    end

    assign inpr_q   = r_inpr;
    assign fgi      = r_fgi;
    assign fgo      = w_fgo;
    assign ien      = r_ien;
    assign irq      = r_irq;
    assign err_ovr  = r_err_ovr;
    assign rx_ready = ~r_fgi;
    assign tx_data  = r_outr;
    assign tx_valid = (r_tx_state == TX_BUSY);

endmodule

// File: tb/tb_bc_io_unit.sv
// Directed bench for bc_io_unit: a queue-based model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_bc_io_unit;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_inp, cpu_out, cpu_ion, cpu_iof, irq_ack;
    logic [DW-1:0] ac_lo, rx_data;
    logic          rx_valid, tx_ready;
    logic [DW-1:0] inpr_q, tx_data;
    logic          fgi, fgo, ien, irq, err_ovr, rx_ready, tx_valid;

    int total = 0;
    int bad   = 0;

    bc_io_unit #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cpu_inp(cpu_inp), .cpu_out(cpu_out), .cpu_ion(cpu_ion),
        .cpu_iof(cpu_iof), .irq_ack(irq_ack), .ac_lo(ac_lo),
        .inpr_q(inpr_q), .fgi(fgi), .fgo(fgo), .ien(ien), .irq(irq),
        .err_ovr(err_ovr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: device-side view of the unit. tx_q holds bytes the device has yet to take.
    logic [DW-1:0] m_inpr, m_outr;
    logic          m_fgi, m_ien, m_irq, m_err;
    logic [DW-1:0] tx_q[$];
    bit            m_ok = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_inpr = '0; m_outr = '0; m_fgi = 0; m_ien = 0; m_irq = 0; m_err = 0;
            tx_q.delete();
            m_ok = 1;
        end else if (m_ok) begin
            bit was_busy;
            bit fgo_pre;
            was_busy = (tx_q.size() != 0);
            fgo_pre  = !was_busy;
            m_irq = m_ien & (m_fgi | fgo_pre);
            if (rx_valid && !m_fgi) begin
                m_inpr = rx_data;
                m_fgi  = 1;
            end else if (cpu_inp) begin
                m_fgi = 0;
            end
            if (was_busy) begin
                if (cpu_out) m_err = 1;
                if (tx_ready) void'(tx_q.pop_front());
            end else if (cpu_out) begin
                m_outr = ac_lo;
                tx_q.push_back(ac_lo);
            end
            if (irq_ack || cpu_iof) m_ien = 0;
            else if (cpu_ion)       m_ien = 1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("inpr_q",   inpr_q,   m_inpr);
            chk("fgi",      fgi,      m_fgi);
            chk("fgo",      fgo,      tx_q.size() == 0);
            chk("ien",      ien,      m_ien);
            chk("irq",      irq,      m_irq);
            chk("err_ovr",  err_ovr,  m_err);
            chk("rx_ready", rx_ready, !m_fgi);
            chk("tx_data",  tx_data,  m_outr);
            chk("tx_valid", tx_valid, tx_q.size() != 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; cpu_inp = 0; cpu_out = 0; cpu_ion = 0; cpu_iof = 0; irq_ack = 0;
        ac_lo = '0; rx_data = '0; rx_valid = 0; tx_ready = 0;
    endtask

    initial begin
        // Reset with garbage on every input
        rst = 1; cpu_inp = 1; cpu_out = 1; cpu_ion = 1; cpu_iof = 0; irq_ack = 0;
        ac_lo = 8'hC3; rx_data = 8'h99; rx_valid = 1; tx_ready = 1;
        tick();
        chk("rst_fgi", fgi, 1'b0);
        chk("rst_fgo", fgo, 1'b1);
        chk("rst_ien", ien, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_txv", tx_valid, 1'b0);
        chk("rst_rxr", rx_ready, 1'b1);
        chk("rst_inpr", inpr_q, 8'h00);
        tick();
        idle_inputs();
        tick();

        // RX then INP
        rx_data = 8'hA5; rx_valid = 1;
        tick();
        chk("rx1_fgi", fgi, 1'b1);
        chk("rx1_inpr", inpr_q, 8'hA5);
        chk("rx1_rdy", rx_ready, 1'b0);
        rx_data = 8'h3C;
        tick(); tick();
        chk("rx2_held", inpr_q, 8'hA5);
        cpu_inp = 1;
        tick();
        cpu_inp = 0;
        chk("inp_fgi", fgi, 1'b0);
        chk("inp_inpr", inpr_q, 8'hA5);
        tick();
        rx_valid = 0;
        chk("rx2_fgi", fgi, 1'b1);
        chk("rx2_inpr", inpr_q, 8'h3C);
        cpu_inp = 1;
        tick();
        cpu_inp = 0;
        chk("inp2_fgi", fgi, 1'b0);
        cpu_inp = 1;
        tick();
        cpu_inp = 0;
        chk("inp_stale", inpr_q, 8'h3C);

        // OUT with backpressure and overrun
        ac_lo = 8'h5A; cpu_out = 1;
        tick();
        cpu_out = 0;
        chk("out_txv", tx_valid, 1'b1);
        chk("out_txd", tx_data, 8'h5A);
        chk("out_fgo", fgo, 1'b0);
        repeat (5) tick();
        chk("bp_txd", tx_data, 8'h5A);
        chk("bp_txv", tx_valid, 1'b1);
        ac_lo = 8'hFF; cpu_out = 1;
        tick();
        cpu_out = 0;
        chk("ovr_txd", tx_data, 8'h5A);
        chk("ovr_err", err_ovr, 1'b1);
        tx_ready = 1;
        tick();
        tx_ready = 0;
        chk("hs_txv", tx_valid, 1'b0);
        chk("hs_fgo", fgo, 1'b1);
        chk("hs_err", err_ovr, 1'b1);

        // OUT in the completing cycle is rejected; the next one is accepted
        ac_lo = 8'h22; cpu_out = 1;
        tick();
        ac_lo = 8'h33; tx_ready = 1;
        tick();
        tx_ready = 0;
        chk("cmp_txv", tx_valid, 1'b0);
        chk("cmp_txd", tx_data, 8'h22);
        tick();
        cpu_out = 0;
        chk("nxt_txd", tx_data, 8'h33);
        chk("nxt_txv", tx_valid, 1'b1);
        tx_ready = 1;
        tick();
        tx_ready = 0;

        // Interrupt enable and request
        cpu_ion = 1;
        tick();
        cpu_ion = 0;
        chk("ion_ien", ien, 1'b1);
        chk("ion_irq0", irq, 1'b0);
        tick();
        chk("ion_irq1", irq, 1'b1);
        irq_ack = 1; cpu_ion = 1;
        tick();
        irq_ack = 0; cpu_ion = 0;
        chk("ack_ien", ien, 1'b0);
        chk("ack_irq_lag", irq, 1'b1);
        tick();
        chk("ack_irq", irq, 1'b0);
        cpu_ion = 1; cpu_iof = 1;
        tick();
        cpu_ion = 0; cpu_iof = 0;
        chk("iof_ien", ien, 1'b0);

        // Reset mid-transfer with a buffered RX byte
        rx_data = 8'h77; rx_valid = 1; ac_lo = 8'h44; cpu_out = 1;
        tick();
        rx_valid = 0; cpu_out = 0;
        chk("pre_fgi", fgi, 1'b1);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_txv", tx_valid, 1'b0);
        chk("mrst_fgo", fgo, 1'b1);
        chk("mrst_err", err_ovr, 1'b0);
        chk("mrst_fgi", fgi, 1'b0);
        chk("mrst_inpr", inpr_q, 8'h00);
        ac_lo = 8'h11; cpu_out = 1;
        tick();
        cpu_out = 0;
        chk("new_txv", tx_valid, 1'b1);
        chk("new_txd", tx_data, 8'h11);
        tx_ready = 1;
        tick();
        tx_ready = 0;
        chk("new_fgo", fgo, 1'b1);
        chk("new_err", err_ovr, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bc_io_unit.md
# bc_io_unit

Peripheral-side I/O unit for the basic computer. It holds the 8-bit input and output registers (INPR, OUTR), their flags (FGI, FGO) and the interrupt enable (IEN). It services the controller's I/O strobes (INP, OUT, SKI, SKO, ION, IOF) on one side and a valid/ready byte stream to an external device on the other. It also raises the registered interrupt request used by the controller's interrupt cycle.

## Interface
- DATA_W, 8, width of INPR/OUTR and device data paths
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_inp  in  1  INP strobe: read INPR onto inpr_q, clear FGI
- cpu_out  in  1  OUT strobe: OUTR <- ac_lo, clear FGO
- cpu_ion  in  1  IEN <- 1
- cpu_iof  in  1  IEN <- 0
- irq_ack  in  1  interrupt taken by controller: IEN <- 0
- ac_lo  in  DATA_W  AC(7:0) from datapath, sampled with cpu_out
- inpr_q  out  DATA_W  current INPR contents (combinational from register)
- fgi  out  1  input flag (SKI tests this)
- fgo  out  1  output flag (SKO tests this)
- ien  out  1  interrupt enable
- irq  out  1  registered request R = IEN & (FGI | FGO)
- err_ovr  out  1  sticky: OUT issued while FGO = 0
- rx_data  in  DATA_W  byte from device
- rx_valid  in  1  device offers rx_data
- rx_ready  out  1  = ~fgi; unit can accept a byte
- tx_data  out  DATA_W  = OUTR
- tx_valid  out  1  OUTR holds an unsent byte
- tx_ready  in  1  device accepts tx_data

## Operation
- Reset values (at the first rising edge with rst = 1): INPR = 0, OUTR = 0, fgi = 0, fgo = 1, ien = 0, irq = 0, err_ovr = 0. The TX FSM goes to TX_IDLE, so tx_valid = 0. rst overrides every other input.
- Receive path:
  - A transfer occurs on an edge where rx_valid & rx_ready. On that edge INPR <- rx_data and fgi <- 1.
  - While fgi = 1, rx_ready = 0 and the device must hold its data.
- INP (cpu_inp = 1):
  - fgi <- 0 at the edge.
  - inpr_q is valid the same cycle; the controller loads AC during the strobe cycle.
  - INP with fgi = 0 is legal. inpr_q shows the stale value and fgi stays 0.
- TX FSM:
  - TX_IDLE (fgo = 1, tx_valid = 0): cpu_out -> OUTR <- ac_lo, fgo <- 0, go to TX_BUSY.
  - TX_BUSY (fgo = 0, tx_valid = 1, tx_data = OUTR held stable): on an edge with tx_ready = 1, go to TX_IDLE and set fgo <- 1.
  - cpu_out in TX_BUSY: ignored. OUTR is unchanged and err_ovr <- 1. err_ovr is cleared only by rst.
- IEN priority:
  - irq_ack or cpu_iof clears IEN.
  - cpu_ion sets IEN only when neither irq_ack nor cpu_iof is asserted.
  - Clear wins over set.
- Interrupt request: irq <= ien & (fgi | fgo), evaluated from the pre-edge values of ien, fgi and fgo.
- More than one of cpu_inp/cpu_out may be high in the same cycle; each is processed independently.
- SKI/SKO need no strobe; the controller reads fgi/fgo directly.

## Timing
- All outputs are registered or direct register fan-out. rx_ready and tx_valid are decoded from flop state only, with no input-to-output combinational path.
- RX: rx_valid high in cycle n with fgi = 0 -> INPR and fgi updated at the end of cycle n. rx_ready is low from cycle n+1.
- Simultaneous cpu_inp and rx_valid with fgi = 1: fgi clears at the end of that cycle with no capture. The capture happens one cycle later, if rx_valid is still high.
- TX: cpu_out in cycle n -> tx_valid high from cycle n+1. A handshake in cycle m -> tx_valid low and fgo high from cycle m+1. Minimum occupancy of TX_BUSY is 1 cycle.
- cpu_out in the same cycle as TX_BUSY completes: treated as busy, so it is rejected and err_ovr is set. The next OUT is accepted one cycle later.
- irq lags flag/IEN changes by exactly 1 cycle.
- rst in TX_BUSY: the byte is dropped, with tx_valid = 0 and fgo = 1 after the edge. rst while fgi = 1: the buffered byte is lost.

## Test plan
- Reset: drive garbage on all inputs with rst = 1 for 2 cycles. Required after the first edge: fgi = 0, fgo = 1, ien = 0, irq = 0, tx_valid = 0, rx_ready = 1, inpr_q = 0x00.
- RX then INP:
  - rx_data = 0xA5 with rx_valid = 1 for 1 cycle -> fgi = 1, inpr_q = 0xA5, rx_ready = 0.
  - A second byte 0x3C held valid is not taken.
  - cpu_inp pulse -> fgi = 0 next cycle, then 0x3C captured one cycle later.
- OUT with backpressure:
  - ac_lo = 0x5A with a cpu_out pulse -> tx_valid = 1, tx_data = 0x5A, fgo = 0.
  - Hold tx_ready = 0 for 5 cycles -> data stable.
  - tx_ready = 1 for 1 cycle -> tx_valid = 0 and fgo = 1 next cycle.
- Overrun: in TX_BUSY, cpu_out with ac_lo = 0xFF -> tx_data stays 0x5A and err_ovr = 1, remaining 1 after completion until rst.
- Interrupt:
  - cpu_ion with fgo = 1 -> ien = 1 next cycle, irq = 1 the cycle after.
  - irq_ack and cpu_ion in the same cycle -> ien = 0 and irq falls 1 cycle later.
- Reset mid-transfer: rst asserted in TX_BUSY with tx_ready = 0 -> tx_valid = 0, fgo = 1 and err_ovr = 0 after the edge. A new OUT of 0x11 is then accepted normally.
